// File: rtl/svga_char_pkg.sv
// svga_char_pkg: character-grid geometry, fetch phase and shared types for the
// SVGA character RAM path.
package svga_char_pkg;
    localparam int CHAR_COLS_800 = 100;
    localparam int CHAR_LINES_800 = 75;
    localparam int CHAR_COLS_640 = 80;
    localparam int CHAR_LINES_640 = 60;
    localparam int CHAR_ADDR_W = 13;
    localparam logic [7:0] CLEAR_CODE = 8'h20;
    localparam logic [2:0] FETCH_PHASE = 3'd5;
    typedef enum logic {ST_IDLE, ST_CLEAR} arb_state_t;
endpackage

// File: rtl/svga_write_fifo.sv
// svga_write_fifo: small synchronous FIFO with registered full/empty; a push
// while full is taken only when a pop frees the slot in the same cycle.
module svga_write_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt, cnt_next;
    logic do_push, do_pop;

    assign do_push = push && (!full || pop);
    assign do_pop = pop && !empty;
    assign cnt_next = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign dout = mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            full <= 1'b0;
            empty <= 1'b1;
        end else begin
            wp <= wp + AW'(do_push);
            rp <= rp + AW'(do_pop);
            cnt <= cnt_next;
            full <= cnt_next == (AW+1)'(DEPTH);
            empty <= cnt_next == '0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/svga_char_ram_arbiter.sv
// svga_char_ram_arbiter: shares one character RAM port between display fetches
// (always granted), a full-screen clear sequence and a queued writer.
module svga_char_ram_arbiter
    import svga_char_pkg::*;
#(
    parameter int CHAR_COLS = CHAR_COLS_800,
    parameter int CHAR_LINES = CHAR_LINES_800,
    parameter int ADDR_W = CHAR_ADDR_W,
    parameter int FIFO_DEPTH = 4,
    parameter logic [7:0] CLEAR_CHAR = CLEAR_CODE
) (
    input  logic              pixel_clock,
    input  logic              reset_n,
    input  logic [6:0]        char_column,
    input  logic [6:0]        char_line,
    input  logic [2:0]        subchar_pixel,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        char_code,
    output logic              char_valid
);
    localparam int TOTAL = CHAR_COLS * CHAR_LINES;
    arb_state_t state, state_next;
    logic [ADDR_W-1:0] clr_addr, clr_addr_next, fetch_addr, fifo_addr;
    logic [ADDR_W+7:0] fifo_dout;
    logic [7:0] fifo_data;
    logic fetch, fetch_d, clr_wr, pop, push, fifo_full, fifo_empty;

    assign fetch = subchar_pixel == FETCH_PHASE && 32'(char_column) < CHAR_COLS
                   && 32'(char_line) < CHAR_LINES;
    assign fetch_addr = ADDR_W'(32'(char_line) * CHAR_COLS + 32'(char_column));
    // The FIFO is held during a clear so queued writes land on top of it.
    assign clr_wr = !fetch && state == ST_CLEAR;
    assign pop = !fetch && state == ST_IDLE && !fifo_empty;
    assign wr_ready = !fifo_full;
    assign push = wr_valid && wr_ready;
    assign clear_busy = state == ST_CLEAR;
    assign {fifo_addr, fifo_data} = fifo_dout;

    svga_write_fifo #(.WIDTH(ADDR_W + 8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(pixel_clock),
        .rst_n(reset_n),
        .push(push),
        .din({wr_addr, wr_data}),
        .pop(pop),
        .dout(fifo_dout),
        .full(fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        state_next = clear_req ? ST_CLEAR
                   : (clr_wr && clr_addr == ADDR_W'(TOTAL - 1)) ? ST_IDLE : state;
        clr_addr_next = clear_req ? '0 : clr_wr ? clr_addr + ADDR_W'(1) : clr_addr;
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            clr_addr <= '0;
        end else begin
            state <= state_next;
            clr_addr <= clr_addr_next;
        end
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr <= '0;
            ram_we <= 1'b0;
            ram_wdata <= '0;
            fetch_d <= 1'b0;
            char_valid <= 1'b0;
            char_code <= '0;
        end else begin
            ram_addr <= fetch ? fetch_addr : clr_wr ? clr_addr : pop ? fifo_addr : ram_addr;
            ram_we <= clr_wr || pop;
            ram_wdata <= clr_wr ? CLEAR_CHAR : pop ? fifo_data : ram_wdata;
            fetch_d <= fetch;
            char_valid <= fetch_d;
            if (fetch_d) char_code <= ram_rdata;
        end
    end
endmodule

// File: tb/tb_svga_char_ram_arbiter.sv
// tb_svga_char_ram_arbiter: directed vectors and multi-cycle sequences against a
// behavioural character RAM.
module tb_svga_char_ram_arbiter;
    logic pixel_clock = 1'b0, reset_n = 1'b0;
    logic [6:0] char_column = '0, char_line = '0;
    logic [2:0] subchar_pixel = '0;
    logic wr_valid = 1'b0, clear_req = 1'b0;
    logic [12:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic wr_ready, clear_busy, ram_we, char_valid;
    logic [12:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata, char_code;

    logic [7:0] mem [0:8191];
    logic loaded = 1'b0;
    logic [12:0] log_a [$];
    logic [7:0] log_d [$];
    int cv_count = 0;
    int checks = 0, errors = 0;

    always #5 pixel_clock = ~pixel_clock;

    svga_char_ram_arbiter dut (
        .pixel_clock(pixel_clock), .reset_n(reset_n),
        .char_column(char_column), .char_line(char_line), .subchar_pixel(subchar_pixel),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .clear_req(clear_req), .clear_busy(clear_busy),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .char_code(char_code), .char_valid(char_valid)
    );

    // Read data follows the registered address within the same cycle.
    assign ram_rdata = mem[ram_addr];

    always @(posedge pixel_clock) begin
        if (!loaded) begin
            for (int i = 0; i < 8192; i++) mem[i] <= (i == 205) ? 8'h41 : 8'(i);
            loaded <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    always @(negedge pixel_clock) begin
        if (ram_we) begin
            log_a.push_back(ram_addr);
            log_d.push_back(ram_wdata);
        end
        if (char_valid) cv_count++;
    end

    typedef struct {
        logic [6:0] line;
        logic [6:0] col;
        logic [2:0] sub;
        logic fetch;
        logic [12:0] addr;
        logic [7:0] code;
    } vec_t;
    vec_t vecs[12];

    task automatic tick();
        @(posedge pixel_clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Clear writes must run 0..7499 (restarting at 0 on a re-request); queued
    // writes must follow the finished clear in acceptance order.
    task automatic analyze(input string tag, input int base, input int restarts, input int nfifo);
        int exp = 0, rs = 0, fi = 0, bad = 0;
        for (int i = base; i < log_a.size(); i++) begin
            if (log_d[i] == 8'h20) begin
                if (int'(log_a[i]) == exp) exp++;
                else if (log_a[i] == 13'd0) begin rs++; exp = 1; end
                else bad++;
            end else begin
                if (exp != 7500 || fi >= nfifo || int'(log_a[i]) != 100 + fi
                    || int'(log_d[i]) != 8'hA0 + fi) bad++;
                fi++;
            end
        end
        chk({tag, "_clear_count"}, exp, 7500);
        chk({tag, "_restarts"}, rs, restarts);
        chk({tag, "_fifo_writes"}, fi, nfifo);
        chk({tag, "_order"}, bad, 0);
    endtask

    task automatic wait_clear_done(input string tag, input int limit);
        int n = 0;
        while (clear_busy && n < limit) begin tick(); n++; end
        chk({tag, "_done"}, clear_busy, 0);
        chk({tag, "_last_we"}, ram_we, 1);
        chk({tag, "_last_addr"}, ram_addr, 7499);
        chk({tag, "_last_data"}, ram_wdata, 8'h20);
    endtask

    initial begin
        int base, cvb, nf, n;
        logic restarted;
        vecs[0]  = '{7'd2,   7'd5,   3'd5, 1'b1, 13'd205,  8'h41};
        vecs[1]  = '{7'd0,   7'd0,   3'd5, 1'b1, 13'd0,    8'h00};
        vecs[2]  = '{7'd74,  7'd99,  3'd5, 1'b1, 13'd7499, 8'h4B};
        vecs[3]  = '{7'd0,   7'd100, 3'd5, 1'b0, 13'd7499, 8'h00};
        vecs[4]  = '{7'd75,  7'd0,   3'd5, 1'b0, 13'd7499, 8'h00};
        vecs[5]  = '{7'd10,  7'd20,  3'd4, 1'b0, 13'd7499, 8'h00};
        vecs[6]  = '{7'd10,  7'd20,  3'd5, 1'b1, 13'd1020, 8'hFC};
        vecs[7]  = '{7'd127, 7'd127, 3'd5, 1'b0, 13'd1020, 8'h00};
        vecs[8]  = '{7'd1,   7'd99,  3'd5, 1'b1, 13'd199,  8'hC7};
        vecs[9]  = '{7'd74,  7'd0,   3'd5, 1'b1, 13'd7400, 8'hE8};
        vecs[10] = '{7'd10,  7'd20,  3'd6, 1'b0, 13'd7400, 8'h00};
        vecs[11] = '{7'd0,   7'd99,  3'd5, 1'b1, 13'd99,   8'h63};

        repeat (3) tick();
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_char_code", char_code, 0);
        chk("rst_char_valid", char_valid, 0);
        chk("rst_clear_busy", clear_busy, 0);
        chk("rst_wr_ready", wr_ready, 1);
        reset_n = 1'b1;
        base = log_a.size();
        repeat (10) tick();
        chk("idle_no_write", log_a.size() - base, 0);

        foreach (vecs[i]) begin
            char_line = vecs[i].line;
            char_column = vecs[i].col;
            subchar_pixel = vecs[i].sub;
            tick();
            subchar_pixel = 3'd0;
            chk($sformatf("vec%0d_addr", i), ram_addr, vecs[i].addr);
            chk($sformatf("vec%0d_we", i), ram_we, 0);
            tick();
            chk($sformatf("vec%0d_valid", i), char_valid, vecs[i].fetch);
            if (vecs[i].fetch) chk($sformatf("vec%0d_code", i), char_code, vecs[i].code);
        end

        char_line = 7'd0; char_column = 7'd3; subchar_pixel = 3'd5;
        wr_valid = 1'b1; wr_addr = 13'd10; wr_data = 8'h33;
        tick();
        wr_valid = 1'b0; subchar_pixel = 3'd0;
        chk("coll_fetch_addr", ram_addr, 3);
        chk("coll_fetch_we", ram_we, 0);
        tick();
        chk("coll_wr_addr", ram_addr, 10);
        chk("coll_wr_we", ram_we, 1);
        chk("coll_wr_data", ram_wdata, 8'h33);
        chk("coll_fetch_code", char_code, 8'h03);
        char_column = 7'd10; subchar_pixel = 3'd5;
        tick();
        subchar_pixel = 3'd0;
        tick();
        chk("coll_readback_valid", char_valid, 1);
        chk("coll_readback_code", char_code, 8'h33);

        base = log_a.size();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("full_clear_busy", clear_busy, 1);
        for (int k = 0; k < 5; k++) begin
            wr_valid = 1'b1; wr_addr = 13'(100 + k); wr_data = 8'(8'hA0 + k);
            chk($sformatf("full_wr_ready%0d", k), wr_ready, k < 4);
            tick();
        end
        wr_valid = 1'b0;
        wait_clear_done("clr1", 10000);
        repeat (8) tick();
        chk("full_wr_ready_after", wr_ready, 1);
        analyze("clr1", base, 0, 4);
        chk("full_mem103", mem[103], 8'hA3);
        chk("full_mem104", mem[104], 8'h20);

        base = log_a.size();
        cvb = cv_count; nf = 0; n = 0; restarted = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        char_line = 7'd3; char_column = 7'd7;
        while (clear_busy && n < 20000) begin
            subchar_pixel = 3'(n % 8);
            if (subchar_pixel == 3'd5) nf++;
            if (!restarted && log_a.size() - base >= 3000) begin
                clear_req = 1'b1;
                restarted = 1'b1;
            end
            tick();
            clear_req = 1'b0;
            n++;
        end
        chk("clr2_done", clear_busy, 0);
        chk("clr2_last_addr", ram_addr, 7499);
        subchar_pixel = 3'd0;
        repeat (3) tick();
        chk("clr2_fetches_served", cv_count - cvb, nf);
        analyze("clr2", base, 1, 0);

        base = log_a.size();
        n = 0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wr_valid = 1'b1; wr_addr = 13'(200 + k); wr_data = 8'(8'hB0 + k);
            tick();
        end
        wr_valid = 1'b0;
        while (log_a.size() - base < 3001 && n < 10000) begin tick(); n++; end
        chk("arst_reached_3000", log_a[log_a.size() - 1], 3000);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_clear_busy", clear_busy, 0);
        chk("arst_ram_we", ram_we, 0);
        chk("arst_ram_addr", ram_addr, 0);
        chk("arst_wr_ready", wr_ready, 1);
        tick();
        reset_n = 1'b1;
        base = log_a.size();
        repeat (20) tick();
        chk("arst_no_writes", log_a.size() - base, 0);
        chk("arst_busy_after", clear_busy, 0);
        chk("arst_mem200", mem[200], 8'h20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/svga_char_ram_arbiter.md
# svga_char_ram_arbiter

Shares one single-port character RAM between the SVGA display fetch path and a writer (counter/CPU logic) that updates displayed characters. Sits between the SVGA timing generator (char_column, char_line, subchar_pixel) and the character ROM/pixel shifter. Display fetches always win their slot; queued writes and a full-screen clear use the remaining cycles.

## Interface
- CHAR_COLS, 100: characters per line (800x600 mode)
- CHAR_LINES, 75: character lines per frame
- ADDR_W, 13: RAM address width; must satisfy 2^ADDR_W >= CHAR_COLS*CHAR_LINES
- FIFO_DEPTH, 4: write-queue entries (power of 2)
- CLEAR_CHAR, 8'h20: code written by clear sequence
- pixel_clock  in  1  pixel clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- char_column  in  7  character column from timing generator
- char_line  in  7  character line from timing generator
- subchar_pixel  in  3  pixel within character; fetch slot when == 3'd5
- wr_valid  in  1  writer request
- wr_ready  out  1  queue not full; write accepted when wr_valid & wr_ready
- wr_addr  in  ADDR_W  target character address
- wr_data  in  8  character code
- clear_req  in  1  single-cycle pulse: start full-screen clear
- clear_busy  out  1  clear sequence in progress
- ram_addr  out  ADDR_W  registered RAM address
- ram_we  out  1  registered RAM write enable
- ram_wdata  out  8  registered RAM write data
- ram_rdata  in  8  RAM read data, valid one cycle after ram_addr
- char_code  out  8  fetched character code to character ROM
- char_valid  out  1  one-cycle strobe, char_code updated

## Operation
- Fetch condition F: subchar_pixel == 5 and char_column < CHAR_COLS and char_line < CHAR_LINES. Fetch address = char_line*CHAR_COLS + char_column, truncated to ADDR_W.
- Port grant per cycle, strict priority: (1) F -> read; (2) state CLEAR -> clear write; (3) FIFO non-empty -> pop and write; (4) idle (ram_we=0, ram_addr holds).
- FIFO: FIFO_DEPTH entries of {addr,data}. Push and pop in same cycle allowed when full (occupancy unchanged, wr_ready stays low that cycle since it reflects registered full). Push when full ignored. Writes retain acceptance order.
- FSM: IDLE -> CLEAR on clear_req; CLEAR keeps pointer clr_addr from 0, increments on each granted clear write; CLEAR -> IDLE after writing address CHAR_COLS*CHAR_LINES-1. clear_req during CLEAR restarts pointer at 0.
- FIFO accepts writes during CLEAR but does not pop until IDLE, so queued writes land after the clear.
- Out-of-range wr_addr (>= CHAR_COLS*CHAR_LINES) still written; no check.

## Timing
- Reset: ram_addr=0, ram_we=0, ram_wdata=0, char_code=0, char_valid=0, clear_busy=0, wr_ready=1, FIFO empty, FSM IDLE.
- F sampled at edge T -> ram_addr/ram_we=0 registered at T+1 -> ram_rdata valid during T+1..T+2 -> char_code and char_valid=1 at T+2 edge (total 2 cycles F to char_code). Timing generator CHARACTER_DECODE_DELAY accounts for this.
- Write accepted at edge T reaches ram_we at T+1 earliest; delayed one cycle per intervening fetch slot. Fetch slots occur at most 1 in 8 cycles, so FIFO drains at >= 7 writes per 8 cycles.
- clear_busy=1 from the edge after clear_req until the edge of the last clear write; clear takes CHAR_COLS*CHAR_LINES writes plus skipped fetch slots.
- reset_n asserted mid-clear or with FIFO occupied: everything returns to reset values immediately; queued writes lost.

## Structure
- Shared package svga_char_pkg: CHAR_COLS/CHAR_LINES per mode, ADDR_W, CLEAR_CHAR, FETCH_PHASE (3'd5).
- One sub-module: svga_write_fifo (synchronous FIFO, registered full/empty, simultaneous push/pop).
- Multiply char_line*CHAR_COLS with constant multiplier; result registered into ram_addr.

## Test plan
- Reset: hold reset_n=0 -> all outputs at reset values, wr_ready=1; release, no activity -> ram_we stays 0.
- Fetch: char_line=2, char_column=5, subchar_pixel=5 -> ram_addr=205, ram_we=0 next cycle; RAM model returns 8'h41 -> char_code=8'h41, char_valid=1 two cycles after F.
- Collision: wr_valid with addr 10 data 8'h33 accepted in same cycle F is true -> fetch read first, write issued next cycle; readback of 10 = 8'h33.
- Full queue: 5 back-to-back writes while slots blocked by clear -> wr_ready low after 4th; all 4 accepted writes appear in order after clear_busy falls.
- Clear: clear_req pulse -> addresses 0..7499 written with 8'h20, no fetch slot missed, clear_busy falls after address 7499; second clear_req mid-way restarts at 0.
- Async reset mid-clear at address 3000 with 2 queued writes -> clear_busy=0, ram_we=0 at once, queued writes never appear.
